pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000: instruction word inserted as a bubble.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset, asynchronous, active-high.
REQ-005 Stall  input  1  hazard hold; freezes PC and the IF/ID register.
REQ-006 Flush  input  1  loads a bubble into IF/ID on the next edge.
REQ-007 BranchEn  input  1  taken-branch redirect.
REQ-008 BranchTarget  input  32  branch target address.
REQ-009 JrEn  input  1  register-jump redirect.
REQ-010 JrTarget  input  32  rs value for jr.
REQ-011 JumpEn  input  1  j/jal redirect.
REQ-012 JumpTarget  input  32  {PC[31:28], addr26, 2'b00} from the jump-address calculator.
REQ-013 Instr  input  32  instruction-memory read data for the current PC (combinational read).
REQ-014 PC  output  32  current fetch address; drives instruction memory and the jump-address calculator.
REQ-015 IF_ID_Instr  output  32  registered instruction.
REQ-016 IF_ID_PCPlus4  output  32  registered PC+4 of that instruction.
REQ-017 IF_ID_Valid  output  1  1 = IF/ID holds a real instruction.
REQ-018 Fault  output  1  sticky misaligned-target indication.

Function
REQ-019 The block SHALL compute PCPlus4 = PC + 32'd4, modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-020 Next-PC priority SHALL be BranchEn > JrEn > JumpEn > PCPlus4.
- The older instruction wins when redirects are simultaneous.
REQ-021 Any asserted redirect SHALL update PC on the next edge even when Stall=1.
- Redirect overrides Stall for the PC only.
REQ-022 With no redirect and Stall=1, PC SHALL hold.
REQ-023 IF/ID update rules SHALL apply in priority order:
- Flush=1: IF/ID loads IF_ID_Instr=NOP_WORD, IF_ID_Valid=0, IF_ID_PCPlus4=PCPlus4. Flush overrides Stall.
- Else Stall=1: IF/ID holds.
- Else: IF/ID loads Instr, PCPlus4 and Valid=1.
REQ-024 FSM states SHALL be RUN and HALT; the block SHALL be in RUN after reset.
REQ-025 In RUN, if the selected redirect target has bits [1:0] != 2'b00, the block SHALL:
- not load that target;
- hold PC;
- load a bubble into IF/ID;
- set Fault=1;
- enter HALT on the same edge.
REQ-026 In HALT:
- PC holds and IF/ID holds the bubble (Valid=0).
- Fault stays 1.
- All inputs except Rst are ignored.
- Only Rst exits HALT.
REQ-027 A misaligned target on a redirect that is not selected by priority SHALL be ignored.
REQ-028 Latency: a redirect asserted in cycle n SHALL appear on PC in cycle n+1; the instruction at that target SHALL appear in IF/ID in cycle n+2.

Reset
REQ-029 On Rst=1, asynchronously and regardless of Clk, the block SHALL set:
- PC=RESET_PC;
- IF_ID_Instr=NOP_WORD, IF_ID_PCPlus4=32'h0, IF_ID_Valid=0;
- Fault=0;
- state=RUN.
REQ-030 Reset asserted mid-stall, mid-redirect or in HALT SHALL override everything.
- The first fetch after deassertion SHALL be from RESET_PC.
REQ-031 The first rising edge after Rst deasserts SHALL load IF/ID with the instruction at RESET_PC, provided Stall=0 and Flush=0.

Structure
REQ-032 A shared package SHALL hold:
- NOP_WORD;
- the FSM state encoding (RUN, HALT);
- the next-PC select encoding (SEL_SEQ, SEL_JUMP, SEL_JR, SEL_BRANCH).
REQ-033 Next-PC priority selection and alignment check SHALL be one combinational sub-module, next_pc_sel.
- Outputs: selected address, select code, misaligned flag.
- PC register, IF/ID register and FSM SHALL live in pc_fetch_unit.

Verification
REQ-034 Sequential fetch: reset, Instr=PC-derived pattern, no control for 4 cycles.
- Required: PC = 0, 4, 8, C.
- Required: IF_ID_PCPlus4 trails PC by one cycle; IF_ID_Valid=1 from the first edge.
REQ-035 Simultaneous redirects:
- JumpEn=1 (JumpTarget=32'h0040_0100) with BranchEn=1 (BranchTarget=32'h0000_0200): next PC=32'h0000_0200.
- JumpEn+JrEn (JrTarget=32'h0000_0300): next PC=32'h0000_0300.
REQ-036 Stall/flush interaction:
- Stall=1 for 3 cycles: PC and IF/ID frozen.
- Stall=1 with JumpEn=1: PC takes the jump target.
- Stall=1 with Flush=1: IF/ID becomes NOP_WORD, Valid=0.
REQ-037 Fault path: JrEn=1, JrTarget=32'h0000_0102.
- Required: PC unchanged, Fault=1, IF_ID_Valid=0.
- Required: further JumpEn has no effect for 5 cycles.
- Required: Rst then restores PC=RESET_PC, Fault=0.
REQ-038 Wrap and async reset:
- PC forced to 32'hFFFF_FFFC via BranchTarget, then run sequentially: next PC=32'h0000_0000.
- Rst pulsed between clock edges: PC=RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: bubble word, FSM states and next-PC select codes.
package pc_fetch_unit_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_JUMP   = 2'd1,
        SEL_JR     = 2'd2,
        SEL_BRANCH = 2'd3
    } pc_sel_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux (branch > jr > jump > sequential) with word-alignment check on the winner.
module next_pc_sel
    import pc_fetch_unit_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic        branch_en,
    input  logic [31:0] branch_target,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    input  logic        jump_en,
    input  logic [31:0] jump_target,
    output logic [31:0] next_pc,
    output pc_sel_t     sel,
    output logic        misaligned
);

    always_comb begin
        next_pc = pc_plus4;
        sel     = SEL_SEQ;
        if (branch_en) begin
            next_pc = branch_target;
            sel     = SEL_BRANCH;
        end else if (jr_en) begin
            next_pc = jr_target;
            sel     = SEL_JR;
        end else if (jump_en) begin
            next_pc = jump_target;
            sel     = SEL_JUMP;
        end
        // Only a chosen redirect can be misaligned; losing targets are never inspected.
        misaligned = (sel != SEL_SEQ) && is_misaligned(next_pc);
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and RUN/HALT fault FSM.
// state | meaning
// RUN   | normal fetch; redirects, stall and flush honoured
// HALT  | misaligned redirect seen; PC and bubble frozen, Fault set, only Rst exits
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = pc_fetch_unit_pkg::NOP_WORD
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchEn,
    input  logic [31:0] BranchTarget,
    input  logic        JrEn,
    input  logic [31:0] JrTarget,
    input  logic        JumpEn,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Instr,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic        Fault
);
    import pc_fetch_unit_pkg::fetch_state_t;
    import pc_fetch_unit_pkg::pc_sel_t;
    import pc_fetch_unit_pkg::RUN;
    import pc_fetch_unit_pkg::HALT;
    import pc_fetch_unit_pkg::SEL_SEQ;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_plus4, sel_pc, pc_d;
    pc_sel_t      sel_code;
    logic         sel_misaligned, redirect;
    logic         ifid_load, ifid_bubble, fault_set;

    assign pc_plus4 = PC + 32'd4;
    assign redirect = (sel_code != SEL_SEQ);

    next_pc_sel u_next_pc_sel (
        .pc_plus4      (pc_plus4),
        .branch_en     (BranchEn),
        .branch_target (BranchTarget),
        .jr_en         (JrEn),
        .jr_target     (JrTarget),
        .jump_en       (JumpEn),
        .jump_target   (JumpTarget),
        .next_pc       (sel_pc),
        .sel           (sel_code),
        .misaligned    (sel_misaligned)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == RUN && sel_misaligned) state_d = HALT;
    end

    always_comb begin
        pc_d        = PC;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        fault_set   = 1'b0;
        if (state_q == RUN) begin
            if (sel_misaligned) begin
                ifid_bubble = 1'b1;
                fault_set   = 1'b1;
            end else begin
                // A redirect moves the PC even under Stall; only sequential advance is held.
                if (redirect || !Stall) pc_d = sel_pc;
                if (Flush)       ifid_bubble = 1'b1;
                else if (!Stall) ifid_load   = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            PC            <= RESET_PC;
            IF_ID_Instr   <= NOP_WORD;
            IF_ID_PCPlus4 <= 32'h0;
            IF_ID_Valid   <= 1'b0;
            Fault         <= 1'b0;
        end else begin
            PC <= pc_d;
            if (ifid_bubble) begin
                IF_ID_Instr   <= NOP_WORD;
                IF_ID_PCPlus4 <= pc_plus4;
                IF_ID_Valid   <= 1'b0;
            end else if (ifid_load) begin
                IF_ID_Instr   <= Instr;
                IF_ID_PCPlus4 <= pc_plus4;
                IF_ID_Valid   <= 1'b1;
            end
            if (fault_set) Fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed scenarios plus randomized control against a cycle model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'hDEAD_0013;

    logic        Clk, Rst, Stall, Flush, BranchEn, JrEn, JumpEn;
    logic [31:0] BranchTarget, JrTarget, JumpTarget, Instr;
    logic [31:0] PC, IF_ID_Instr, IF_ID_PCPlus4;
    logic        IF_ID_Valid, Fault;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] p4;
        logic        valid;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference state
    logic [31:0] m_pc, m_instr, m_p4;
    logic        m_valid, m_fault;

    pc_fetch_unit #(.RESET_PC(RST_PC), .NOP_WORD(NOP)) dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
        .BranchEn(BranchEn), .BranchTarget(BranchTarget),
        .JrEn(JrEn), .JrTarget(JrTarget),
        .JumpEn(JumpEn), .JumpTarget(JumpTarget),
        .Instr(Instr), .PC(PC),
        .IF_ID_Instr(IF_ID_Instr), .IF_ID_PCPlus4(IF_ID_PCPlus4),
        .IF_ID_Valid(IF_ID_Valid), .Fault(Fault)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    assign Instr = instr_of(PC);

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_pc"},    PC, m_pc);
        chk({tag, "_instr"}, IF_ID_Instr, m_instr);
        chk({tag, "_p4"},    IF_ID_PCPlus4, m_p4);
        chk({tag, "_valid"}, {31'b0, IF_ID_Valid}, {31'b0, m_valid});
        chk({tag, "_fault"}, {31'b0, Fault}, {31'b0, m_fault});
    endtask

    always @(posedge Clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_pc",    PC, e.pc);
            chk("sb_instr", IF_ID_Instr, e.instr);
            chk("sb_p4",    IF_ID_PCPlus4, e.p4);
            chk("sb_valid", {31'b0, IF_ID_Valid}, {31'b0, e.valid});
            chk("sb_fault", {31'b0, Fault}, {31'b0, e.fault});
        end
    end

    task automatic model_reset();
        m_pc = RST_PC; m_instr = NOP; m_p4 = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
    endtask

    // One clock of fetch behaviour, written from the rules directly.
    task automatic model_clock();
        logic        redir;
        logic [31:0] tgt, p4;
        if (m_fault) return;
        p4    = m_pc + 32'd4;
        redir = BranchEn || JrEn || JumpEn;
        tgt   = BranchEn ? BranchTarget : (JrEn ? JrTarget : JumpTarget);
        if (redir && tgt[1:0] != 2'b00) begin
            m_fault = 1'b1; m_instr = NOP; m_valid = 1'b0; m_p4 = p4;
            return;
        end
        if (Flush) begin
            m_instr = NOP; m_valid = 1'b0; m_p4 = p4;
        end else if (!Stall) begin
            m_instr = instr_of(m_pc); m_valid = 1'b1; m_p4 = p4;
        end
        if (redir)       m_pc = tgt;
        else if (!Stall) m_pc = p4;
    endtask

    task automatic step(input logic st, input logic fl,
                        input logic be, input logic [31:0] bt,
                        input logic je, input logic [31:0] jt,
                        input logic pe, input logic [31:0] pt);
        exp_t e;
        @(negedge Clk);
        Stall = st; Flush = fl;
        BranchEn = be; BranchTarget = bt;
        JrEn = je; JrTarget = jt;
        JumpEn = pe; JumpTarget = pt;
        model_clock();
        e.pc = m_pc; e.instr = m_instr; e.p4 = m_p4; e.valid = m_valid; e.fault = m_fault;
        sb.push_back(e);
        @(posedge Clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asserted between edges; values must change without any clock edge.
    task automatic do_reset(input string tag);
        Rst = 1'b1;
        model_reset();
        #1;
        chk_model(tag);
        @(posedge Clk);
        #2;
        Rst = 1'b0;
    endtask

    initial begin
        logic [31:0] pc_hold, t;
        Stall = 0; Flush = 0; BranchEn = 0; JrEn = 0; JumpEn = 0;
        BranchTarget = 0; JrTarget = 0; JumpTarget = 0;
        Rst = 1'b1;
        do_reset("rst0");

        // Sequential fetch
        idle(4);
        chk("seq_pc", PC, 32'h0000_0010);
        chk("seq_ifid_p4", IF_ID_PCPlus4, 32'h0000_0010);
        chk("seq_valid", {31'b0, IF_ID_Valid}, 32'd1);

        // Simultaneous redirects
        step(0, 0, 1, 32'h0000_0200, 0, 0, 1, 32'h0040_0100);
        chk("br_over_jump", PC, 32'h0000_0200);
        step(0, 0, 0, 0, 1, 32'h0000_0300, 1, 32'h0040_0100);
        chk("jr_over_jump", PC, 32'h0000_0300);
        idle(1);
        chk("redir_ifid", IF_ID_Instr, instr_of(32'h0000_0300));

        // Stall / flush
        pc_hold = PC;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("stall_pc", PC, pc_hold);
        step(1, 0, 0, 0, 0, 0, 1, 32'h0040_0100);
        chk("stall_jump", PC, 32'h0040_0100);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        chk("stall_flush_instr", IF_ID_Instr, NOP);
        chk("stall_flush_valid", {31'b0, IF_ID_Valid}, 32'd0);
        idle(2);

        // Misaligned jr -> HALT
        pc_hold = PC;
        step(0, 0, 0, 0, 1, 32'h0000_0102, 0, 0);
        chk("fault_pc", PC, pc_hold);
        chk("fault_flag", {31'b0, Fault}, 32'd1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 1, 32'h0000_0800);
        chk("halt_pc", PC, pc_hold);
        do_reset("rst_halt");
        chk("rst_fault", {31'b0, Fault}, 32'd0);

        // Losing misaligned target ignored
        step(0, 0, 1, 32'h0000_0040, 1, 32'h0000_0003, 0, 0);
        chk("ignored_misalign", PC, 32'h0000_0040);

        // Wrap and async reset mid-stall
        step(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        idle(1);
        chk("wrap_pc", PC, 32'h0000_0000);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        do_reset("rst_async");
        chk("rst_async_pc", PC, RST_PC);
        idle(1);
        chk("first_fetch", IF_ID_Instr, instr_of(RST_PC));

        // Randomized control
        for (int i = 0; i < 400; i++) begin
            logic st, fl, be, je, pe;
            logic [31:0] bt, jt, pt;
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 6) == 0);
            be = ($urandom_range(0, 7) == 0);
            je = ($urandom_range(0, 7) == 0);
            pe = ($urandom_range(0, 7) == 0);
            bt = $urandom() & ~32'h3;
            jt = $urandom() & ~32'h3;
            pt = $urandom() & ~32'h3;
            if ($urandom_range(0, 15) == 0) bt = bt | $urandom_range(1, 3);
            if ($urandom_range(0, 15) == 0) jt = jt | $urandom_range(1, 3);
            if ($urandom_range(0, 15) == 0) pt = pt | $urandom_range(1, 3);
            step(st, fl, be, bt, je, jt, pe, pt);
            if ((m_fault && $urandom_range(0, 3) == 0) || $urandom_range(0, 49) == 0)
                do_reset("rst_rand");
        end

        @(negedge Clk);
        @(negedge Clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
